// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan driver.
//   SEG_TABLE : hex nibble -> active-low segment pattern (bit 0 = a .. bit 6 = g)
//   SEG_BLANK : all segments dark
//   AN_*/DP_* : active-low drive levels for anodes and decimal point
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  // Entry 15 first in the concatenation, so SEG_TABLE[n] is the pattern for n.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic AN_ON  = 1'b0;
  localparam logic AN_OFF = 1'b1;
  localparam logic DP_ON  = 1'b0;
  localparam logic DP_OFF = 1'b1;

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// seg7_decode: combinational hex-nibble to active-low 7-segment decoder.
//   i_nibble : 4-bit hex value
//   o_seg_c  : active-low segments, bit 0 = a .. bit 6 = g
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] i_nibble,
  output logic [SEG_W-1:0] o_seg_c
);

  assign o_seg_c = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a NUM_DIGITS hex display.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture data/dp_in into the shadow registers
//   data       : hex nibbles, nibble i drives digit i (digit 0 least significant)
//   dp_in      : per-digit decimal point request (1 = lit)
//   digit_en   : live per-digit enable (1 = may light)
//   lz_blank   : live leading-zero suppression enable
//   seg, dp    : active-low segments / decimal point (registered)
//   an         : active-low digit anodes, at most one low (registered)
//   scan_tick  : one-cycle pulse when the slot index advances
// Each slot lasts 2^DIV_WIDTH cycles; the first BLANK_CYCLES of a slot are dark
// to avoid ghosting while the anodes switch.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIV_WIDTH    = 17,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [NIB_W*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic                        lz_blank,
  output logic [SEG_W-1:0]            seg,
  output logic                        dp,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        scan_tick
);

  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DATA_W = NIB_W * NUM_DIGITS;
  localparam logic [DIV_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [DIV_WIDTH-1:0] BLANK_CNT = DIV_WIDTH'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Elaboration-time parameter legality
  if (NUM_DIGITS == 0 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seg7_scan_driver: NUM_DIGITS must be 1..8");
  end
  if (DIV_WIDTH == 0 || (64'(BLANK_CYCLES) >> DIV_WIDTH) != 64'd0) begin : g_bad_blank
    $error("seg7_scan_driver: BLANK_CYCLES must be below 2^DIV_WIDTH");
  end

  logic [DIV_WIDTH-1:0]  r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_W-1:0]     r_data;
  logic [NUM_DIGITS-1:0] r_dp;
  logic [SEG_W-1:0]      r_seg;
  logic                  r_dp_out;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_tick;

  logic [DIV_WIDTH-1:0]  w_cnt_next;
  logic [IDX_W-1:0]      w_idx_next;
  logic [DATA_W-1:0]     w_data_next;
  logic [NUM_DIGITS-1:0] w_dp_sh_next;
  logic [SEG_W-1:0]      w_seg_next;
  logic                  w_dp_next;
  logic [NUM_DIGITS-1:0] w_an_next;
  logic                  w_wrap;
  logic                  w_blank;

  logic [NUM_DIGITS-1:0] w_zero_from;
  logic [NIB_W-1:0]      w_nibble;
  logic                  w_en_sel;
  logic                  w_dp_sel;
  logic                  w_zero_sel;
  logic [NUM_DIGITS-1:0] w_an_sel;
  logic [SEG_W-1:0]      w_seg_dec;

  // w_zero_from[i]: nibbles i..NUM_DIGITS-1 of the shadow value are all zero
  always_comb begin
    w_zero_from = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_zero_from[i] = ((r_data >> (NIB_W * i)) == '0);
    end
  end

  // Per-slot selection of nibble, enables and anode pattern by current index
  always_comb begin
    w_nibble   = '0;
    w_en_sel   = 1'b0;
    w_dp_sel   = 1'b0;
    w_zero_sel = 1'b0;
    w_an_sel   = {NUM_DIGITS{AN_OFF}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nibble    = r_data[NIB_W*i +: NIB_W];
        w_en_sel    = digit_en[i];
        w_dp_sel    = r_dp[i];
        w_zero_sel  = w_zero_from[i];
        w_an_sel[i] = AN_ON;
      end
    end
  end

  seg7_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg_c  (w_seg_dec)
  );

  // Next-state and next-output logic
  always_comb begin
    w_cnt_next   = r_cnt + DIV_WIDTH'(1);
    w_wrap       = (r_cnt == CNT_MAX);
    w_idx_next   = r_idx;
    w_data_next  = r_data;
    w_dp_sh_next = r_dp;

    if (w_wrap) begin
      w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end
    if (load) begin
      w_data_next  = data;
      w_dp_sh_next = dp_in;
    end

    // Digit 0 is exempt from leading-zero suppression so zero still shows "0"
    w_blank = (r_cnt < BLANK_CNT) || !w_en_sel ||
              (lz_blank && (r_idx != '0) && w_zero_sel);

    w_seg_next = w_blank ? SEG_BLANK : w_seg_dec;
    w_dp_next  = (w_blank || !w_dp_sel) ? DP_OFF : DP_ON;
    w_an_next  = w_blank ? {NUM_DIGITS{AN_OFF}} : w_an_sel;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_dp     <= '0;
      r_seg    <= SEG_BLANK;
      r_dp_out <= DP_OFF;
      r_an     <= {NUM_DIGITS{AN_OFF}};
      r_tick   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_idx    <= w_idx_next;
      r_data   <= w_data_next;
      r_dp     <= w_dp_sh_next;
      r_seg    <= w_seg_next;
      r_dp_out <= w_dp_next;
      r_an     <= w_an_next;
      r_tick   <= w_wrap;
    end
  end

  assign seg       = r_seg;
  assign dp        = r_dp_out;
  assign an        = r_an;
  assign scan_tick = r_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: self-checking bench for seg7_scan_driver
// (NUM_DIGITS=4, DIV_WIDTH=4, BLANK_CYCLES=2).
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int BC = 2;
  localparam int SLOT = 1 << DW;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        scan_tick;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       tick;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  int          m_cnt;
  int          m_idx;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic [6:0]  ref_tab [16];
  int          tick_count;
  logic        seen_an13;

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .DIV_WIDTH    (DW),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data      (data),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .lz_blank  (lz_blank),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_idx  = 0;
    m_data = '0;
    m_dp   = '0;
  endtask

  // Expected registered outputs for the edge about to happen
  function automatic exp_t model_exp();
    exp_t       e;
    logic       blank;
    logic       allz;
    logic [3:0] nib;
    nib  = m_data[4*m_idx +: 4];
    allz = 1'b1;
    for (int j = m_idx; j < ND; j++) begin
      if (m_data[4*j +: 4] != 4'h0) allz = 1'b0;
    end
    blank  = (m_cnt < BC) || !digit_en[m_idx] || (lz_blank && m_idx != 0 && allz);
    e.tick = (m_cnt == SLOT - 1);
    if (blank) begin
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.an  = 4'hF;
    end else begin
      e.seg        = ref_tab[nib];
      e.dp         = ~m_dp[m_idx];
      e.an         = 4'hF;
      e.an[m_idx]  = 1'b0;
    end
    return e;
  endfunction

  // One clock: push expectation, advance model, pop and compare
  task automatic step();
    exp_t e;
    sb_q.push_back(model_exp());
    @(posedge clk);
    if (load) begin
      m_data = data;
      m_dp   = dp_in;
    end
    if (m_cnt == SLOT - 1) m_idx = (m_idx + 1) % ND;
    m_cnt = (m_cnt + 1) % SLOT;
    #1;
    e = sb_q.pop_front();
    chk("sb_seg",  32'(seg),       32'(e.seg));
    chk("sb_dp",   32'(dp),        32'(e.dp));
    chk("sb_an",   32'(an),        32'(e.an));
    chk("sb_tick", 32'(scan_tick), 32'(e.tick));
    chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    if (scan_tick) tick_count++;
    if (!an[1] || !an[3]) seen_an13 = 1'b1;
  endtask

  // Advance until the counter/index about to be sampled equals (idx, cnt)
  task automatic goto_state(input int idx, input int cnt);
    int n;
    n = 0;
    while (!(m_idx == idx && m_cnt == cnt) && n < 80) begin
      step();
      n++;
    end
    total++;
    assert (n < 80) else begin
      bad++;
      $error("FAIL goto_timeout observed=%0d expected=<80", n);
    end
  endtask

  // Make outputs reflect state (idx, cnt)
  task automatic show(input int idx, input int cnt);
    goto_state(idx, cnt);
    step();
  endtask

  initial begin
    ref_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    tick_count = 0;
    seen_an13  = 1'b0;
    rst      = 1'b0;
    load     = 1'b0;
    data     = '0;
    dp_in    = '0;
    digit_en = 4'hF;
    lz_blank = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_an",   32'(an),        32'hF);
    chk("rst_seg",  32'(seg),       32'h7F);
    chk("rst_dp",   32'(dp),        32'h1);
    chk("rst_tick", 32'(scan_tick), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // 12AF, dp on digit 2, load on first edge after reset
    data = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
    step();
    load = 1'b0;
    show(0, 7); chk("d0_an", 32'(an), 32'hE); chk("d0_seg", 32'(seg), 32'h0E); chk("d0_dp", 32'(dp), 32'h1);
    show(1, 7); chk("d1_an", 32'(an), 32'hD); chk("d1_seg", 32'(seg), 32'h08); chk("d1_dp", 32'(dp), 32'h1);
    show(2, 7); chk("d2_an", 32'(an), 32'hB); chk("d2_seg", 32'(seg), 32'h24); chk("d2_dp", 32'(dp), 32'h0);
    show(3, 7); chk("d3_an", 32'(an), 32'h7); chk("d3_seg", 32'(seg), 32'h79); chk("d3_dp", 32'(dp), 32'h1);

    // Leading-zero suppression with 0050
    data = 16'h0050; dp_in = 4'b0000; lz_blank = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    show(0, 7); chk("lz0_seg", 32'(seg), 32'h40); chk("lz0_an", 32'(an), 32'hE);
    show(1, 7); chk("lz1_seg", 32'(seg), 32'h12); chk("lz1_an", 32'(an), 32'hD);
    show(2, 7); chk("lz2_an", 32'(an), 32'hF);
    show(3, 7); chk("lz3_an", 32'(an), 32'hF);

    // All-zero value: only digit 0 lit
    data = 16'h0000; load = 1'b1;
    step();
    load = 1'b0;
    show(0, 7); chk("z0_seg", 32'(seg), 32'h40); chk("z0_an", 32'(an), 32'hE);
    show(1, 7); chk("z1_an", 32'(an), 32'hF);
    show(2, 7); chk("z2_an", 32'(an), 32'hF);
    show(3, 7); chk("z3_an", 32'(an), 32'hF);

    // Shadow holds when data changes without load
    lz_blank = 1'b0; data = 16'h1234; load = 1'b1;
    step();
    load = 1'b0; data = 16'hFFFF;
    show(0, 7); chk("sh0_seg", 32'(seg), 32'h19);
    show(1, 7); chk("sh1_seg", 32'(seg), 32'h30);
    show(2, 7); chk("sh2_seg", 32'(seg), 32'h24);
    show(3, 7); chk("sh3_seg", 32'(seg), 32'h79);

    // Load coinciding with slot advance
    goto_state(0, SLOT - 1);
    data = 16'h0030; load = 1'b1;
    step();
    load = 1'b0;
    show(1, 2); chk("ldadv_seg", 32'(seg), 32'h30); chk("ldadv_an", 32'(an), 32'hD);

    // Anti-ghost blank window at slot start
    show(2, 0); chk("bl0_an", 32'(an), 32'hF); chk("bl0_seg", 32'(seg), 32'h7F);
    step();     chk("bl1_an", 32'(an), 32'hF);
    step();     chk("bl2_an", 32'(an), 32'hB); chk("bl2_seg", 32'(seg), 32'h40);

    // Disabled digits 1 and 3 over one full scan
    digit_en = 4'b0101;
    goto_state(0, 0);
    tick_count = 0;
    seen_an13  = 1'b0;
    repeat (4 * SLOT) step();
    chk("scan_ticks", 32'(tick_count), 32'd4);
    chk("an13_dark",  32'(seen_an13),  32'd0);

    // Asynchronous reset mid-slot
    digit_en = 4'hF; data = 16'h9876; load = 1'b1;
    step();
    load = 1'b0;
    goto_state(2, 7);
    #1 rst = 1'b1;
    #1;
    chk("arst_an",   32'(an),        32'hF);
    chk("arst_seg",  32'(seg),       32'h7F);
    chk("arst_dp",   32'(dp),        32'h1);
    chk("arst_tick", 32'(scan_tick), 32'h0);
    model_reset();
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    show(0, 2); chk("post_seg", 32'(seg), 32'h40); chk("post_an", 32'(an), 32'hE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter DIV_WIDTH, default 17: refresh counter width; each digit slot lasts 2^DIV_WIDTH clk cycles.
REQ-003 SHALL have parameter BLANK_CYCLES, default 16: anti-ghost blank at the start of each slot, legal range 0..2^DIV_WIDTH-1.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port load, input, 1: when high at a clk edge, data/dp_in are captured into shadow registers.
REQ-007 SHALL have port data, input, 4*NUM_DIGITS: hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant.
REQ-008 SHALL have port dp_in, input, NUM_DIGITS: per-digit decimal point request, 1 = lit.
REQ-009 SHALL have port digit_en, input, NUM_DIGITS: live per-digit enable, 1 = digit may light; not latched.
REQ-010 SHALL have port lz_blank, input, 1: live leading-zero suppression enable.
REQ-011 SHALL have port seg, output, 7: active-low segments, seg[0]=a through seg[6]=g.
REQ-012 SHALL have port dp, output, 1: active-low decimal point.
REQ-013 SHALL have port an, output, NUM_DIGITS: active-low digit anodes; at most one bit low at any time.
REQ-014 SHALL have port scan_tick, output, 1: one-cycle pulse when the slot index advances.

Function
REQ-015 Refresh counter SHALL be DIV_WIDTH bits, free-running, +1 every cycle, wrapping all-ones -> 0.
REQ-016 When the counter is all-ones, slot index SHALL advance next cycle: i -> i+1, NUM_DIGITS-1 -> 0; scan_tick SHALL be high in that same cycle the counter wraps.
REQ-017 Shadow data/dp SHALL change only on load; data changes without load SHALL NOT affect outputs.
REQ-018 seg, dp, an SHALL be registered, reflecting the counter, index and shadow values of the previous cycle (latency 1 cycle).
REQ-019 Load and slot advance in the same cycle SHALL both take effect; the new slot decodes the new shadow value.
REQ-020 Decode SHALL map nibble 0..F to seg = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, gfedcba, active-low).
REQ-021 A digit i>0 SHALL be LZ-blanked when lz_blank=1 and nibbles i..NUM_DIGITS-1 are all zero; digit 0 SHALL never be LZ-blanked.
REQ-022 While counter < BLANK_CYCLES, an SHALL be all ones, seg 7F, dp 1.
REQ-023 A slot whose digit is disabled (digit_en bit 0) or LZ-blanked SHALL drive an all ones, seg 7F, dp 1 for the whole slot; slot timing SHALL be unchanged.
REQ-024 Otherwise an SHALL have only the current-index bit low, seg the decoded shadow nibble, dp = ~shadow dp bit.

Reset
REQ-025 Asserting rst SHALL immediately force counter 0, index 0, shadow data 0, shadow dp 0, an all ones, seg 7F, dp 1, scan_tick 0, including mid-slot.
REQ-026 After rst deasserts, the first clk edge SHALL begin slot 0 with the counter at 0; load SHALL be honoured on that edge.

Structure
REQ-027 Package seg7_pkg SHALL hold the 16-entry decode table, the blank pattern 7F and the active-low polarity constants.
REQ-028 A combinational sub-module seg7_decode (nibble in, 7-bit active-low pattern out) SHALL be instantiated once, fed by an index-selected nibble.
REQ-029 Parameter legality (REQ-001, REQ-003) SHALL be checked at elaboration.

Verification (NUM_DIGITS=4, DIV_WIDTH=4, BLANK_CYCLES=2)
REQ-030 Load 16'h12AF, dp_in 4'b0100, all digits enabled, lz_blank 0 -> slot0 an 1110 seg 0E; slot1 an 1101 seg 08; slot2 an 1011 seg 24 dp 0; slot3 an 0111 seg 79.
REQ-031 Load 16'h0050, lz_blank 1 -> slots 3 and 2 an 1111; slot1 seg 12; slot0 seg 40. Load 16'h0000 -> only slot0 lit, seg 40.
REQ-032 After loading 16'h1234, change data to 16'hFFFF with load low -> displayed digits remain 4,3,2,1.
REQ-033 digit_en 4'b0101 -> an bits 1 and 3 never low; scan_tick every 16 cycles; full scan 64 cycles.
REQ-034 Each slot -> an 1111 for the first 2 output cycles, then one active bit for 14 cycles; never two bits low.
REQ-035 Assert rst at counter 7 in slot 2 -> an 1111, seg 7F, dp 1 with no clk edge; after release, slot 0 follows with shadow 0 (seg 40 if enabled).
